// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the scalar and vector
// execution units. Each unit has a small request FIFO; a round-robin arbiter
// drains one write per cycle onto registered rf_* outputs.
//
// state      | meaning
// -----------+----------------------------------------------------------
// OUT_IDLE   | no write this cycle, all rf_* outputs zero
// OUT_WR_SCA | scalar write on the port (rf_wd_vec forced to zero)
// OUT_WR_VEC | vector write on the port (rf_wd_sca forced to zero)
// GNT_SCA    | last grant went to scalar, vector wins the next tie
// GNT_VEC    | last grant went to vector, scalar wins the next tie
module wb_port_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sca_valid,
  output logic                    sca_ready,
  input  logic [ADDR_W-1:0]       sca_addr,
  input  logic [DATA_W-1:0]       sca_data,
  input  logic                    vec_valid,
  output logic                    vec_ready,
  input  logic [ADDR_W-1:0]       vec_addr,
  input  logic [LANES*DATA_W-1:0] vec_data,
  output logic                    rf_we,
  output logic [ADDR_W-1:0]       rf_a3,
  output logic [DATA_W-1:0]       rf_wd_sca,
  output logic [LANES*DATA_W-1:0] rf_wd_vec,
  output logic                    illegal_addr,
  output logic                    busy
);

  localparam int VEC_W = LANES * DATA_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {GNT_SCA, GNT_VEC} grant_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_WR_SCA, OUT_WR_VEC} out_t;

  logic [ADDR_W-1:0] sca_addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] sca_data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] vec_addr_mem [FIFO_DEPTH];
  logic [VEC_W-1:0]  vec_data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] sca_wr_ptr, sca_rd_ptr, vec_wr_ptr, vec_rd_ptr;
  logic [CNT_W-1:0] sca_cnt, vec_cnt;
  grant_t           last_grant;
  out_t             out_state;

  logic sca_acc, vec_acc, sca_push, vec_push;
  logic sca_ne, vec_ne, sca_pop, vec_pop, ill_next;

  // ready looks only at registered occupancy, so valid never reaches ready
  assign sca_ready = sca_cnt < CNT_W'(FIFO_DEPTH);
  assign vec_ready = vec_cnt < CNT_W'(FIFO_DEPTH);
  assign sca_acc   = sca_valid && sca_ready;
  assign vec_acc   = vec_valid && vec_ready;
  // scalar lives in R0-R7, vector in R8-R15; wrong-class requests are swallowed
  assign sca_push  = sca_acc && !sca_addr[ADDR_W-1];
  assign vec_push  = vec_acc && vec_addr[ADDR_W-1];
  assign ill_next  = (sca_acc && sca_addr[ADDR_W-1]) || (vec_acc && !vec_addr[ADDR_W-1]);

  assign sca_ne  = sca_cnt != '0;
  assign vec_ne  = vec_cnt != '0;
  assign sca_pop = sca_ne && (!vec_ne || last_grant == GNT_VEC);
  assign vec_pop = vec_ne && !sca_pop;

  assign rf_we = out_state != OUT_IDLE;
  assign busy  = sca_ne || vec_ne || rf_we;

  // FIFO payload storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (sca_push) begin
      sca_addr_mem[sca_wr_ptr] <= sca_addr;
      sca_data_mem[sca_wr_ptr] <= sca_data;
    end
    if (vec_push) begin
      vec_addr_mem[vec_wr_ptr] <= vec_addr;
      vec_data_mem[vec_wr_ptr] <= vec_data;
    end
  end

  // scalar FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sca_wr_ptr <= '0;
      sca_rd_ptr <= '0;
      sca_cnt    <= '0;
    end else begin
      if (sca_push) sca_wr_ptr <= sca_wr_ptr + PTR_W'(1);
      if (sca_pop)  sca_rd_ptr <= sca_rd_ptr + PTR_W'(1);
      case ({sca_push, sca_pop})
        2'b10:   sca_cnt <= sca_cnt + CNT_W'(1);
        2'b01:   sca_cnt <= sca_cnt - CNT_W'(1);
        default: sca_cnt <= sca_cnt;
      endcase
    end
  end

  // vector FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_wr_ptr <= '0;
      vec_rd_ptr <= '0;
      vec_cnt    <= '0;
    end else begin
      if (vec_push) vec_wr_ptr <= vec_wr_ptr + PTR_W'(1);
      if (vec_pop)  vec_rd_ptr <= vec_rd_ptr + PTR_W'(1);
      case ({vec_push, vec_pop})
        2'b10:   vec_cnt <= vec_cnt + CNT_W'(1);
        2'b01:   vec_cnt <= vec_cnt - CNT_W'(1);
        default: vec_cnt <= vec_cnt;
      endcase
    end
  end

  // round-robin grant and registered write-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= GNT_VEC;
      out_state    <= OUT_IDLE;
      rf_a3        <= '0;
      rf_wd_sca    <= '0;
      rf_wd_vec    <= '0;
      illegal_addr <= 1'b0;
    end else begin
      illegal_addr <= ill_next;
      if (sca_pop) begin
        last_grant <= GNT_SCA;
        out_state  <= OUT_WR_SCA;
        rf_a3      <= sca_addr_mem[sca_rd_ptr];
        rf_wd_sca  <= sca_data_mem[sca_rd_ptr];
        rf_wd_vec  <= '0;
      end else if (vec_pop) begin
        last_grant <= GNT_VEC;
        out_state  <= OUT_WR_VEC;
        rf_a3      <= vec_addr_mem[vec_rd_ptr];
        rf_wd_sca  <= '0;
        rf_wd_vec  <= vec_data_mem[vec_rd_ptr];
      end else begin
        out_state  <= OUT_IDLE;
        rf_a3      <= '0;
        rf_wd_sca  <= '0;
        rf_wd_vec  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: hand-written vector table, fairness and
// reset sequences, and random traffic against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sca_valid = 1'b0, vec_valid = 1'b0;
  logic       sca_ready, vec_ready;
  logic [3:0] sca_addr = '0, sca_data = '0, vec_addr = '0;
  logic [7:0] vec_data = '0;
  logic       rf_we, illegal_addr, busy;
  logic [3:0] rf_a3, rf_wd_sca;
  logic [7:0] rf_wd_vec;

  wb_port_arbiter dut (
    .clk(clk), .rst(rst),
    .sca_valid(sca_valid), .sca_ready(sca_ready), .sca_addr(sca_addr), .sca_data(sca_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_addr(vec_addr), .vec_data(vec_data),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd_sca(rf_wd_sca), .rf_wd_vec(rf_wd_vec),
    .illegal_addr(illegal_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model: pending requests per source plus who was served last
  logic [7:0]  sq[$];
  logic [11:0] vq[$];
  bit          last_vec;
  logic        m_acc_s, m_acc_v;
  logic [11:0] wlog[$];

  typedef struct {
    logic       sv;
    logic [3:0] sa;
    logic [3:0] sd;
    logic       vv;
    logic [3:0] va;
    logic [7:0] vd;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic sv, logic [3:0] sa, logic [3:0] sd,
                              logic vv, logic [3:0] va, logic [7:0] vd,
                              logic we, logic [3:0] a3, logic [3:0] wsca,
                              logic [7:0] wvec, logic ill, logic bsy);
    vec_t r;
    r.sv = sv; r.sa = sa; r.sd = sd; r.vv = vv; r.va = va; r.vd = vd;
    r.exp = {we, a3, wsca, wvec, ill, bsy, 2'b11};
    return r;
  endfunction

  function automatic logic [20:0] get_obs();
    return {rf_we, rf_a3, rf_wd_sca, rf_wd_vec, illegal_addr, busy, sca_ready, vec_ready};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // one clock with the given request inputs, checked against the model
  task automatic step(input logic sv, input logic [3:0] sa, input logic [3:0] sd,
                      input logic vv, input logic [3:0] va, input logic [7:0] vd,
                      output logic [20:0] obs);
    logic        acc_s, acc_v, we, ill, bsy;
    logic [3:0]  a3, wsca;
    logic [7:0]  wvec, e;
    logic [11:0] ve;
    logic [20:0] exp;
    sca_valid = sv; sca_addr = sa; sca_data = sd;
    vec_valid = vv; vec_addr = va; vec_data = vd;
    acc_s = sv && (sq.size() < DEPTH);
    acc_v = vv && (vq.size() < DEPTH);
    ill   = (acc_s && sa[3]) || (acc_v && !va[3]);
    we = 1'b0; a3 = '0; wsca = '0; wvec = '0;
    if (sq.size() > 0 && (vq.size() == 0 || last_vec)) begin
      e = sq.pop_front();
      we = 1'b1; a3 = e[7:4]; wsca = e[3:0]; last_vec = 1'b0;
    end else if (vq.size() > 0) begin
      ve = vq.pop_front();
      we = 1'b1; a3 = ve[11:8]; wvec = ve[7:0]; last_vec = 1'b1;
    end
    if (acc_s && !sa[3]) sq.push_back({sa, sd});
    if (acc_v && va[3])  vq.push_back({va, vd});
    bsy = (sq.size() > 0) || (vq.size() > 0) || we;
    exp = {we, a3, wsca, wvec, ill, bsy, sq.size() < DEPTH, vq.size() < DEPTH};
    m_acc_s = acc_s;
    m_acc_v = acc_v;
    @(posedge clk);
    #1;
    cyc++;
    obs = get_obs();
    check("cycle_model", 32'(obs), 32'(exp));
    if (rf_we) wlog.push_back({rf_a3, rf_a3[3] ? rf_wd_vec : {4'h0, rf_wd_sca}});
  endtask

  task automatic idle(output logic [20:0] obs);
    step(1'b0, 4'h0, 4'h0, 1'b0, 4'h8, 8'h00, obs);
  endtask

  // async reset asserted between edges; outputs must clear without a clock
  task automatic do_reset();
    sca_valid = 1'b0;
    vec_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check("reset_async_outputs", 32'(get_obs() >> 2), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    sq.delete();
    vq.delete();
    last_vec = 1'b1;
    check("reset_release_ready_busy", {29'h0, sca_ready, vec_ready, busy}, 32'h6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] obs;
    logic [11:0] exp_w;
    int s, v, c;
    bit got, we_seen;

    tbl[0]  = mk(1, 4'h1, 4'h5, 1, 4'h9, 8'hCA, 0, 4'h0, 4'h0, 8'h00, 0, 1);
    tbl[1]  = mk(0, 4'h0, 4'h0, 0, 4'h8, 8'h00, 1, 4'h1, 4'h5, 8'h00, 0, 1);
    tbl[2]  = mk(0, 4'h0, 4'h0, 0, 4'h8, 8'h00, 1, 4'h9, 4'h0, 8'hCA, 0, 1);
    tbl[3]  = mk(0, 4'h0, 4'h0, 0, 4'h8, 8'h00, 0, 4'h0, 4'h0, 8'h00, 0, 0);
    tbl[4]  = mk(1, 4'h3, 4'hA, 0, 4'h8, 8'h00, 0, 4'h0, 4'h0, 8'h00, 0, 1);
    tbl[5]  = mk(0, 4'h0, 4'h0, 0, 4'h8, 8'h00, 1, 4'h3, 4'hA, 8'h00, 0, 1);
    tbl[6]  = mk(0, 4'h0, 4'h0, 0, 4'h8, 8'h00, 0, 4'h0, 4'h0, 8'h00, 0, 0);
    tbl[7]  = mk(1, 4'h8, 4'h7, 0, 4'h8, 8'h00, 0, 4'h0, 4'h0, 8'h00, 1, 0);
    tbl[8]  = mk(0, 4'h0, 4'h0, 0, 4'h8, 8'h00, 0, 4'h0, 4'h0, 8'h00, 0, 0);
    tbl[9]  = mk(0, 4'h0, 4'h0, 1, 4'h2, 8'h33, 0, 4'h0, 4'h0, 8'h00, 1, 0);
    tbl[10] = mk(0, 4'h0, 4'h0, 0, 4'h8, 8'h00, 0, 4'h0, 4'h0, 8'h00, 0, 0);
    tbl[11] = mk(1, 4'h9, 4'h1, 1, 4'h4, 8'h22, 0, 4'h0, 4'h0, 8'h00, 1, 0);
    tbl[12] = mk(0, 4'h0, 4'h0, 0, 4'h8, 8'h00, 0, 4'h0, 4'h0, 8'h00, 0, 0);

    // reset, then tie / single scalar / illegal-class vectors
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].sv, tbl[i].sa, tbl[i].sd, tbl[i].vv, tbl[i].va, tbl[i].vd, obs);
      check($sformatf("table_%0d", i), 32'(obs), 32'(tbl[i].exp));
    end

    // both sources stream 4 requests under backpressure; writes must alternate
    do_reset();
    wlog.delete();
    s = 0; v = 0; c = 0;
    while (c < 40 && (s < 4 || v < 4 || sq.size() > 0 || vq.size() > 0)) begin
      step(s < 4, 4'(s), 4'(s + 1), v < 4, 4'(8 + v), 8'(v * 16 + 15 - v), obs);
      if (m_acc_s) s++;
      if (m_acc_v) v++;
      c++;
    end
    check("fair_drained_in_budget", 32'(c < 40), 32'h1);
    check("fair_write_count", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) exp_w = {4'(i / 2), 8'(i / 2 + 1)};
      else            exp_w = {4'(8 + i / 2), 8'((i / 2) * 16 + 15 - i / 2)};
      check($sformatf("fair_order_%0d", i), 32'(i < wlog.size() ? wlog[i] : 12'hFFF), 32'(exp_w));
    end

    // random traffic, occasional wrong-class addresses
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ra, rva;
      ra  = 4'($urandom_range(0, 7));
      rva = 4'($urandom_range(8, 15));
      if ($urandom_range(0, 7) == 0) ra[3] = 1'b1;
      if ($urandom_range(0, 7) == 0) rva[3] = 1'b0;
      step(1'($urandom_range(0, 1)), ra, 4'($urandom), 1'($urandom_range(0, 1)), rva,
           8'($urandom), obs);
    end

    // reset in the middle of a burst drops everything still queued
    do_reset();
    step(1, 4'h0, 4'h1, 1, 4'h8, 8'h11, obs);
    step(1, 4'h1, 4'h2, 1, 4'h9, 8'h22, obs);
    got = 1'b0;
    if (obs[20]) got = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      idle(obs);
      if (obs[20]) got = 1'b1;
    end
    check("midop_first_write_seen", 32'(got), 32'h1);
    do_reset();
    we_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(obs);
      if (obs[20]) we_seen = 1'b1;
    end
    check("midop_no_write_after_reset", 32'(we_seen), 32'h0);
    step(1, 4'h2, 4'h3, 1, 4'hA, 8'h44, obs);
    idle(obs);
    check("midop_tie_goes_scalar", 32'({obs[20], obs[19:16], obs[15:12]}), 32'h123);
    idle(obs);
    idle(obs);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
